pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//   Parametrised inter-stage pipeline register with valid/ready flow control, synchronous
//   flush (bubble insertion) and an optional 2-entry skid buffer.
//   Generic replacement for the fixed-width stage registers (decode->exec, exec->mem, ...).
//   Payload = control field + data field. A zero control field is the NOP encoding.
//   Adds stall, flush, reset and a stall-cycle counter for hazard-unit and perf use.
// PARAMETERS
//   CTRL_W  35  width of control-signal field (all-zero = NOP)
//   DATA_W  61  width of data field (operands, imm, shamt, reg ids, int flags, packed)
//   SKID    1   1: 2-entry skid, in_ready registered; 0: single entry, in_ready combinational
//   CNT_W   16  width of stall_cnt
// PORTS
//   clk        in   1       clock, all state updates on posedge
//   rst_n      in   1       async reset, active-low
//   flush      in   1       sync kill: discard all held and incoming entries
//   in_valid   in   1       upstream entry present
//   in_ready   out  1       block accepts entry this cycle (transfer = in_valid & in_ready)
//   in_ctrl    in   CTRL_W  upstream control signals
//   in_data    in   DATA_W  upstream data payload
//   out_valid  out  1       entry present for downstream
//   out_ready  in   1       downstream consumes (transfer = out_valid & out_ready)
//   out_ctrl   out  CTRL_W  control to next stage; forced 0 when out_valid=0
//   out_data   out  DATA_W  data to next stage (main register contents)
//   occupancy  out  2       entries held: 0, 1, 2
//   stall_cnt  out  CNT_W   saturating count of cycles with out_valid & !out_ready
// BEHAVIOUR
//   Reset (async, rst_n=0): state EMPTY, main/skid regs 0, out_valid=0, out_ctrl=0,
//     out_data=0, occupancy=0, stall_cnt=0, in_ready=1. Mid-operation reset drops all entries.
//   State machine (SKID=1); in_ready = (state!=FULL), decoded from state register only:
//     EMPTY: in_valid           -> main<=in, BUSY
//     BUSY : in_valid & out_ready  -> main<=in, stay BUSY (full throughput)
//            in_valid & !out_ready -> skid<=in, FULL
//            !in_valid & out_ready -> EMPTY
//            otherwise             -> hold
//     FULL : out_ready  -> main<=skid, BUSY (no accept: in_ready=0)
//            !out_ready -> hold
//   SKID=0: single entry, in_ready = !out_valid | out_ready (comb); occupancy max 1.
//     Same EMPTY/BUSY rules; FULL unreachable.
//   Latency: accepted entry appears on out_* the cycle after acceptance (1 cycle).
//   Ordering: strict FIFO; skid entry always leaves before any later entry.
//   Flush (highest priority, sync): next state EMPTY.
//     Main/skid ctrl cleared to 0; data regs keep their value.
//     Entry presented with flush is not stored.
//     in_ready keeps its state-derived value that cycle; flush wins over simultaneous accept.
//   out_valid = (state!=EMPTY); out_ctrl = out_valid ? main_ctrl : 0.
//   Held entries stay stable while out_valid & !out_ready.
//   stall_cnt increments by 1 per stall cycle and saturates at 2^CNT_W-1.
//     No wrap; unaffected by flush; cleared only by reset.
//   No X propagation: every register has a reset value.
// TESTING
//   1. Reset, stream 4 entries ctrl=1..4, out_ready=1
//      -> out_valid 1 cycle after each accept, ctrl 1,2,3,4, in_ready always 1.
//   2. SKID=1, main holds ctrl=5, out_ready=0, push ctrl=6
//      -> occupancy=2, in_ready=0.
//      Then out_ready=1 -> outputs 5 then 6; in_ready=1 on the cycle after 5 leaves.
//   3. FULL state, assert flush with in_valid=1, ctrl=9
//      -> next cycle out_valid=0, out_ctrl=0, occupancy=0; ctrl 9 never appears.
//   4. CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles
//      -> stall_cnt=15, stays 15; flush does not clear it.
//   5. Drop rst_n mid-stream at occupancy=2
//      -> immediately out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0, without waiting for a clock edge.
//   6. SKID=0, out_valid=1, out_ready toggles every cycle, in_valid=1
//      -> in_ready mirrors out_ready; no entry lost or duplicated.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with valid/ready handshaking,
// synchronous flush, an optional 2-entry skid buffer and a saturating
// stall-cycle counter. A zero control field is the NOP encoding.
module pipe_stage_elastic #(
   parameter int CTRL_W = 35,
   parameter int DATA_W = 61,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   // Outputs decoded from the state register; in_ready only looks at
   // out_ready when there is no skid slot to absorb a stalled transfer.
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      out_ctrl  = out_valid ? main_ctrl_q : '0;
      out_data  = main_data_q;
      stall_cnt = stall_cnt_q;
      if (SKID != 0) begin
         in_ready = (state_q != ST_FULL);
      end else begin
         in_ready = (state_q == ST_EMPTY) || out_ready;
      end
      case (state_q)
         ST_BUSY: occupancy = 2'd1;
         ST_FULL: occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // Next-state and datapath: flush beats everything, then FIFO moves.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         // Killed entries become NOPs; data payload is don't-care and kept.
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
                  state_d     = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (in_valid && out_ready) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (in_valid && (SKID != 0)) begin
                  // Downstream stalled while we had already promised ready.
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
                  state_d     = ST_FULL;
               end else if (!in_valid && out_ready) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  state_d     = ST_BUSY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Saturating count of cycles where an entry waits on downstream.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State and payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: payload registers are reset too so no X ever reaches out_data.
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: a skid and a non-skid stage see identical stimulus;
// a FIFO reference model per stage predicts handshakes and outputs.
module tb_pipe_stage_elastic;

   localparam int CTRL_W = 35;
   localparam int DATA_W = 61;
   localparam int CNT_W  = 4;
   localparam int SAT    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_ready = 1'b0;

   logic              in_ready_s, out_valid_s, in_ready_n, out_valid_n;
   logic [CTRL_W-1:0] out_ctrl_s, out_ctrl_n;
   logic [DATA_W-1:0] out_data_s, out_data_n;
   logic [1:0]        occ_s, occ_n;
   logic [CNT_W-1:0]  stall_s, stall_n;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } pkt_t;

   // Reference model: per stage, an ordered list of held entries.
   pkt_t mq [2][2];
   int   mcnt [2];
   int   mstall [2];

   always #5 clk = ~clk;

   pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(CNT_W)) u_sk (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s), .out_data(out_data_s),
      .occupancy(occ_s), .stall_cnt(stall_s)
   );

   pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(CNT_W)) u_ns (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_n), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid_n), .out_ready(out_ready), .out_ctrl(out_ctrl_n), .out_data(out_data_n),
      .occupancy(occ_n), .stall_cnt(stall_n)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // One model cycle for stage s: compare what the DUT presents, then
   // advance the FIFO according to the handshakes about to happen.
   task automatic side_step(input int s, input bit sk, input logic ir, input logic ov,
                            input logic [1:0] occ, input logic [CNT_W-1:0] st,
                            input logic [CTRL_W-1:0] oc, input logic [DATA_W-1:0] od);
      string pfx;
      bit    exp_ir;
      pfx    = sk ? "skid" : "noskid";
      exp_ir = sk ? (mcnt[s] < 2) : ((mcnt[s] == 0) || out_ready);
      check({pfx, "_in_ready"}, 64'(ir), 64'(exp_ir));
      check({pfx, "_out_valid"}, 64'(ov), 64'(mcnt[s] > 0));
      check({pfx, "_occupancy"}, 64'(occ), 64'(mcnt[s]));
      check({pfx, "_stall_cnt"}, 64'(st), 64'(mstall[s]));
      if (mcnt[s] > 0) begin
         check({pfx, "_out_ctrl"}, 64'(oc), 64'(mq[s][0].ctrl));
         check({pfx, "_out_data"}, 64'(od), 64'(mq[s][0].data));
      end else begin
         check({pfx, "_out_ctrl_idle"}, 64'(oc), 64'd0);
      end
      if ((mcnt[s] > 0) && !out_ready && (mstall[s] < SAT)) mstall[s]++;
      if (flush) begin
         mcnt[s] = 0;
      end else begin
         if ((mcnt[s] > 0) && out_ready) begin
            mq[s][0] = mq[s][1];
            mcnt[s]--;
         end
         if (in_valid && exp_ir) begin
            mq[s][mcnt[s]] = '{ctrl: in_ctrl, data: in_data};
            mcnt[s]++;
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < 2; s++) begin
            mcnt[s]   = 0;
            mstall[s] = 0;
         end
      end else begin
         side_step(0, 1'b1, in_ready_s, out_valid_s, occ_s, stall_s, out_ctrl_s, out_data_s);
         side_step(1, 1'b0, in_ready_n, out_valid_n, occ_n, stall_n, out_ctrl_n, out_data_n);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int c, input logic ordy, input logic fl);
      in_valid  = v;
      in_ctrl   = CTRL_W'(c);
      in_data   = DATA_W'({$urandom(), $urandom()});
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state.
      #2;
      check("rst_in_ready", 64'(in_ready_s), 64'd1);
      check("rst_out_valid", 64'(out_valid_s), 64'd0);
      check("rst_out_data", 64'(out_data_s), 64'd0);
      check("rst_stall", 64'(stall_s), 64'd0);
      step();
      step();
      rst_n = 1'b1;

      // Stream 1..4 with downstream always ready: one-cycle latency, in order.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, i, 1'b1, 1'b0);
         #1 check("t1_in_ready", 64'(in_ready_s), 64'd1);
         step();
         check("t1_out_valid", 64'(out_valid_s), 64'd1);
         check("t1_out_ctrl", 64'(out_ctrl_s), 64'(i));
      end
      drive(1'b0, 0, 1'b1, 1'b0);
      step();

      // Fill skid: 5 in main, 6 in skid, then drain in order.
      drive(1'b1, 5, 1'b0, 1'b0);
      step();
      drive(1'b1, 6, 1'b0, 1'b0);
      step();
      drive(1'b0, 0, 1'b0, 1'b0);
      #1;
      check("t2_occupancy", 64'(occ_s), 64'd2);
      check("t2_in_ready", 64'(in_ready_s), 64'd0);
      check("t2_out_ctrl", 64'(out_ctrl_s), 64'd5);
      out_ready = 1'b1;
      step();
      check("t2_second_ctrl", 64'(out_ctrl_s), 64'd6);
      check("t2_ready_back", 64'(in_ready_s), 64'd1);
      step();

      // Flush in FULL with a simultaneous offer of ctrl 9.
      drive(1'b1, 7, 1'b0, 1'b0);
      step();
      drive(1'b1, 8, 1'b0, 1'b0);
      step();
      drive(1'b1, 9, 1'b0, 1'b1);
      step();
      drive(1'b0, 0, 1'b1, 1'b0);
      #1;
      check("t3_out_valid", 64'(out_valid_s), 64'd0);
      check("t3_out_ctrl", 64'(out_ctrl_s), 64'd0);
      check("t3_occupancy", 64'(occ_s), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_no_ghost", 64'(out_valid_s), 64'd0);
      end

      // Stall counter saturation, immune to flush.
      do_reset();
      drive(1'b1, 11, 1'b0, 1'b0);
      step();
      drive(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step();
      check("t4_stall_sat", 64'(stall_s), 64'(SAT));
      check("t4_stall_sat_ns", 64'(stall_n), 64'(SAT));
      drive(1'b0, 0, 1'b0, 1'b1);
      step();
      drive(1'b0, 0, 1'b0, 1'b0);
      step();
      check("t4_stall_after_flush", 64'(stall_s), 64'(SAT));

      // Asynchronous reset with two entries held.
      drive(1'b1, 12, 1'b0, 1'b0);
      step();
      drive(1'b1, 13, 1'b0, 1'b0);
      step();
      drive(1'b0, 0, 1'b0, 1'b0);
      #1 check("t5_pre_occupancy", 64'(occ_s), 64'd2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t5_out_valid", 64'(out_valid_s), 64'd0);
      check("t5_out_ctrl", 64'(out_ctrl_s), 64'd0);
      check("t5_in_ready", 64'(in_ready_s), 64'd1);
      check("t5_stall", 64'(stall_s), 64'd0);
      check("t5_occupancy", 64'(occ_s), 64'd0);
      step();
      rst_n = 1'b1;

      // Non-skid stage with toggling downstream: in_ready follows out_ready.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 100 + i, i[0], 1'b0);
         #1;
         if (i > 0) check("t6_ready_mirror", 64'(in_ready_n), 64'(out_ready));
         step();
      end
      drive(1'b0, 0, 1'b1, 1'b0);
      step();
      step();

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 7, int'($urandom()), $urandom_range(0, 9) < 6,
               $urandom_range(0, 39) == 0);
         step();
      end
      drive(1'b0, 0, 1'b1, 1'b0);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
